// File: rtl/m_store_unit.sv
// ----------------------------------------------------------------------------
// m_store_unit
//
// Store path between the M stage and a simple single-outstanding write bus.
// A store request is narrowed to a word-aligned bus write: the store data is
// replicated across the byte lanes, and byte enables select the bytes to write.
// Misaligned halfword and word stores raise a one-cycle address-error pulse
// (ades) and never reach the bus.
//
// Optional feature (compile-time macro M_STORE_UNIT_TIMEOUT_EN):
//   When this macro is defined, a write that receives no bus_ack within
//   TIMEOUT_CYCLES cycles is abandoned. The unit then pulses bus_err for one
//   cycle and returns to IDLE. When the macro is undefined, the unit waits for
//   bus_ack indefinitely and bus_err is always 0.
//
// Parameters
//   TIMEOUT_CYCLES : bus-wait limit in cycles (used only with the timeout feature)
//
// Ports
//   clk        in   1   single clock, rising edge
//   reset      in   1   asynchronous, active-low reset
//   st_valid   in   1   store request from the M stage
//   st_op      in   2   00 none, 01 sb, 10 sh, 11 sw
//   st_addr    in  32   byte address of the store
//   st_data    in  32   register value to store
//   st_ready   out  1   unit is idle and accepts a request this cycle
//   st_done    out  1   one-cycle pulse when the bus write completes
//   ades       out  1   one-cycle pulse on a misaligned store
//   bus_req    out  1   bus write request
//   bus_addr   out 32   word-aligned write address
//   bus_wdata  out 32   lane-replicated write data
//   bus_be     out  4   byte enables (0000 while bus_req is low)
//   bus_ack    in   1   write acknowledge, sampled with bus_req high
//   bus_err    out  1   one-cycle pulse on a bus timeout
// ----------------------------------------------------------------------------
module m_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    output logic        st_done,
    output logic        ades,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    output logic        bus_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_SB   = 2'b01;
    localparam logic [1:0] OP_SH   = 2'b10;
    localparam logic [1:0] OP_SW   = 2'b11;

    state_t      r_state;
    logic        r_bus_req;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;
    logic        r_st_done;
    logic        r_ades;
    logic        r_bus_err;

    logic        w_misaligned;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;

`ifdef M_STORE_UNIT_TIMEOUT_EN
    // The counter holds 0 .. TIMEOUT_CYCLES-1. Each value marks one REQ cycle that has
    // already elapsed without bus_ack.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_wait_cnt;
`else
    // The parameter stays on the interface so both builds have the same
    // instantiation. This build does not use it.
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

    // Narrow the request: lane-replicate the data and derive the byte
    // enables and alignment check from the low address bits.
    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        w_misaligned = 1'b0;
        w_wdata      = st_data;
        w_be         = 4'b0000;
        case (st_op)
            OP_SB: begin
                w_wdata = {4{st_data[7:0]}};
                w_be    = 4'b0001 << st_addr[1:0];
            end
            OP_SH: begin
                w_wdata      = {2{st_data[15:0]}};
                w_be         = st_addr[1] ? 4'b1100 : 4'b0011;
                w_misaligned = st_addr[0];
            end
            OP_SW: begin
                w_wdata      = st_data;
                w_be         = 4'b1111;
                w_misaligned = (st_addr[1:0] != 2'b00);
            end
            default: begin
                w_wdata = st_data;
                w_be    = 4'b0000;
            end
        endcase
    end

    // Control FSM. All bus-facing outputs come from registers. Pulse outputs
    // default to 0 each cycle, so any pulse lasts exactly one cycle.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_bus_req   <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_bus_be    <= 4'b0000;
            r_st_done   <= 1'b0;
            r_ades      <= 1'b0;
            r_bus_err   <= 1'b0;
`ifdef M_STORE_UNIT_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            r_st_done <= 1'b0;
            r_ades    <= 1'b0;
            r_bus_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (st_valid && (st_op != OP_NONE)) begin
                        if (w_misaligned) begin
                            r_ades <= 1'b1;
                        end else begin
                            r_state     <= S_REQ;
                            r_bus_req   <= 1'b1;
                            r_bus_addr  <= {st_addr[31:2], 2'b00};
                            r_bus_wdata <= w_wdata;
                            r_bus_be    <= w_be;
`ifdef M_STORE_UNIT_TIMEOUT_EN
                            r_wait_cnt  <= '0;
`endif
                        end
                    end
                end
                S_REQ: begin
                    // bus_ack is checked before the timeout. An ack on the last
                    // counted cycle therefore completes the store.
                    if (bus_ack) begin
                        r_state   <= S_IDLE;
                        r_bus_req <= 1'b0;
                        r_bus_be  <= 4'b0000;
                        r_st_done <= 1'b1;
`ifdef M_STORE_UNIT_TIMEOUT_EN
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == CNT_LAST) begin
                        r_state    <= S_IDLE;
                        r_bus_req  <= 1'b0;
                        r_bus_be   <= 4'b0000;
                        r_bus_err  <= 1'b1;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_bus_req <= 1'b0;
                    r_bus_be  <= 4'b0000;
                end
            endcase
        end
    end

    assign st_ready  = (r_state == S_IDLE);
    assign st_done   = r_st_done;
    assign ades      = r_ades;
    assign bus_req   = r_bus_req;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_be    = r_bus_be;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_m_store_unit.sv
// ----------------------------------------------------------------------------
// tb_m_store_unit
//
// Directed testbench for m_store_unit. Each stimulus vector uses expected
// values worked out by hand. Inputs change, and outputs are sampled, 1 ns after
// each rising clock edge.
// ----------------------------------------------------------------------------
module tb_m_store_unit;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        st_done;
    logic        ades;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic        bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    m_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_op     (st_op),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_ready  (st_ready),
        .st_done   (st_done),
        .ades      (ades),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        st_valid = v;
        st_op    = op;
        st_addr  = a;
        st_data  = d;
    endtask

    // Present an aligned store, let it be accepted, and acknowledge it in the
    // first REQ cycle. Then check the bus fields and the done pulse.
    task automatic store_imm_ack(input string tag, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] exp_addr,
                                 input logic [31:0] exp_wdata, input logic [3:0] exp_be);
        drive(1'b1, op, a, d);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check({tag, "_req"},   {31'b0, bus_req}, 32'd1);
        check({tag, "_addr"},  bus_addr, exp_addr);
        check({tag, "_wdata"}, bus_wdata, exp_wdata);
        check({tag, "_be"},    {28'b0, bus_be}, {28'b0, exp_be});
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check({tag, "_done"},  {31'b0, st_done}, 32'd1);
        check({tag, "_be_off"}, {28'b0, bus_be}, 32'd0);
        step();
        check({tag, "_done_pulse"}, {31'b0, st_done}, 32'd0);
    endtask

    initial begin
        int hi;
        reset   = 1'b0;
        bus_ack = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);

        // Reset state.
        #12;
        check("rst_ready", {31'b0, st_ready}, 32'd1);
        check("rst_req",   {31'b0, bus_req}, 32'd0);
        check("rst_be",    {28'b0, bus_be}, 32'd0);
        check("rst_addr",  bus_addr, 32'h0);
        check("rst_wdata", bus_wdata, 32'h0);
        check("rst_flags", {29'b0, st_done, ades, bus_err}, 32'd0);
        reset = 1'b1;
        step();

        // bus_ack while idle is ignored. st_op=00 with st_valid is ignored.
        bus_ack = 1'b1;
        drive(1'b1, 2'b00, 32'h0000_0003, 32'hDEAD_BEEF);
        step();
        bus_ack = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("idle_ack_done", {31'b0, st_done}, 32'd0);
        check("nop_req",       {31'b0, bus_req}, 32'd0);
        check("nop_ades",      {31'b0, ades}, 32'd0);
        check("nop_ready",     {31'b0, st_ready}, 32'd1);

        // sb to byte 3, ack after 2 cycles. A new request while in REQ is ignored.
        drive(1'b1, 2'b01, 32'h0000_1003, 32'h1234_56AB);
        step();
        drive(1'b1, 2'b11, 32'h0000_5000, 32'h5555_5555);
        check("sb_req",   {31'b0, bus_req}, 32'd1);
        check("sb_ready", {31'b0, st_ready}, 32'd0);
        check("sb_addr",  bus_addr, 32'h0000_1000);
        check("sb_be",    {28'b0, bus_be}, 32'h8);
        check("sb_wdata", bus_wdata, 32'hABAB_ABAB);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("sb_hold_addr",  bus_addr, 32'h0000_1000);
        check("sb_hold_wdata", bus_wdata, 32'hABAB_ABAB);
        check("sb_hold_done",  {31'b0, st_done}, 32'd0);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check("sb_done",    {31'b0, st_done}, 32'd1);
        check("sb_req_off", {31'b0, bus_req}, 32'd0);
        check("sb_be_off",  {28'b0, bus_be}, 32'd0);
        check("sb_ready2",  {31'b0, st_ready}, 32'd1);
        step();
        check("sb_done_pulse", {31'b0, st_done}, 32'd0);

        // Narrowing across lanes, with an immediate ack (done in cycle N+2).
        store_imm_ack("sh_hi", 2'b10, 32'h0000_2002, 32'hFFFF_8001, 32'h0000_2000, 32'h8001_8001, 4'b1100);
        store_imm_ack("sh_lo", 2'b10, 32'h0000_2000, 32'h1234_BEEF, 32'h0000_2000, 32'hBEEF_BEEF, 4'b0011);
        store_imm_ack("sb_b1", 2'b01, 32'h0000_4001, 32'h0000_00CD, 32'h0000_4000, 32'hCDCD_CDCD, 4'b0010);
        store_imm_ack("sw",    2'b11, 32'h0000_6004, 32'h0102_0304, 32'h0000_6004, 32'h0102_0304, 4'b1111);

        // Misaligned sw: one ades pulse and no bus activity.
        drive(1'b1, 2'b11, 32'h0000_3002, 32'h1111_2222);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("ades_sw",       {31'b0, ades}, 32'd1);
        check("ades_sw_req",   {31'b0, bus_req}, 32'd0);
        check("ades_sw_ready", {31'b0, st_ready}, 32'd1);
        step();
        check("ades_sw_pulse", {31'b0, ades}, 32'd0);
        check("ades_sw_req2",  {31'b0, bus_req}, 32'd0);

        // Misaligned sh (odd address).
        drive(1'b1, 2'b10, 32'h0000_2001, 32'h0);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("ades_sh",     {31'b0, ades}, 32'd1);
        check("ades_sh_req", {31'b0, bus_req}, 32'd0);
        step();

        // Reset during REQ abandons the write. The next store then behaves normally.
        drive(1'b1, 2'b11, 32'h0000_0010, 32'hAAAA_5555);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("rreq_req", {31'b0, bus_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rreq_req_off", {31'b0, bus_req}, 32'd0);
        check("rreq_ready",   {31'b0, st_ready}, 32'd1);
        check("rreq_be",      {28'b0, bus_be}, 32'd0);
        step();
        reset = 1'b1;
        step();
        check("rreq_no_done", {30'b0, st_done, bus_err}, 32'd0);
        store_imm_ack("post_rst", 2'b11, 32'h0000_0020, 32'hCAFE_F00D, 32'h0000_0020, 32'hCAFE_F00D, 4'b1111);

        // Back-to-back sw: the second store is accepted in the st_done cycle.
        drive(1'b1, 2'b11, 32'h0000_7000, 32'h0000_0001);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check("b2b_done1",  {31'b0, st_done}, 32'd1);
        check("b2b_ready1", {31'b0, st_ready}, 32'd1);
        drive(1'b1, 2'b11, 32'h0000_7004, 32'h0000_0002);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        check("b2b_req2",   {31'b0, bus_req}, 32'd1);
        check("b2b_addr2",  bus_addr, 32'h0000_7004);
        check("b2b_wdata2", bus_wdata, 32'h0000_0002);
        check("b2b_gap",    {31'b0, st_done}, 32'd0);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check("b2b_done2", {31'b0, st_done}, 32'd1);
        step();

`ifdef M_STORE_UNIT_TIMEOUT_EN
        // No ack: bus_req is high for 4 cycles, then one bus_err pulse.
        drive(1'b1, 2'b11, 32'h0000_8000, 32'h0);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        hi = 0;
        while (bus_req && hi < 10) begin
            hi++;
            step();
        end
        check("to_req_cycles", hi, 32'd4);
        check("to_err",        {31'b0, bus_err}, 32'd1);
        check("to_ready",      {31'b0, st_ready}, 32'd1);
        check("to_no_done",    {31'b0, st_done}, 32'd0);
        step();
        check("to_err_pulse", {31'b0, bus_err}, 32'd0);

        // An ack on the final counted cycle completes the store.
        drive(1'b1, 2'b11, 32'h0000_8004, 32'h0);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        step();
        step();
        step();
        check("to_last_req", {31'b0, bus_req}, 32'd1);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check("to_last_done", {31'b0, st_done}, 32'd1);
        check("to_last_err",  {31'b0, bus_err}, 32'd0);
        step();
`else
        // Without the timeout feature, REQ waits indefinitely.
        drive(1'b1, 2'b11, 32'h0000_8000, 32'h0);
        step();
        drive(1'b0, 2'b00, 32'h0, 32'h0);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_req && !bus_err) hi++;
            step();
        end
        check("wait_req_cycles", hi, 32'd20);
        check("wait_req_still",  {31'b0, bus_req}, 32'd1);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        check("wait_done", {31'b0, st_done}, 32'd1);
        check("wait_err",  {31'b0, bus_err}, 32'd0);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
